// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write/read-side arbiters.
package fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  localparam int ARB_DSIZE_DEF     = 128;
  localparam int ARB_BURST_LEN_DEF = 8;

  // Index width for a requester count; never narrower than one bit.
  function automatic int ARB_IDW(input int nreq);
    return (nreq <= 2) ? 1 : $clog2(nreq);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted req searching from last+1 mod NREQ.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]          req,
  input  logic [ARB_IDW(NREQ)-1:0] last,
  output logic                     any,
  output logic [ARB_IDW(NREQ)-1:0] idx
);

  localparam int IDW = ARB_IDW(NREQ);

  always_comb begin
    logic [IDW-1:0] k;
    any = 1'b0;
    idx = '0;
    k   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      k = IDW'((int'(last) + i) % NREQ);
      if (!any && req[k]) begin
        any = 1'b1;
        idx = k;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the dual-clock FIFO write port among NREQ producers.
// Define WR_ARB_BURST_EN to hold each grant for up to BURST_LEN words; otherwise word-level round-robin.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DSIZE     = ARB_DSIZE_DEF,
  parameter int BURST_LEN = ARB_BURST_LEN_DEF
) (
  input  logic                     wclk,
  input  logic                     wrst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DSIZE-1:0]    din,
  output logic [NREQ-1:0]          ack,
  input  logic                     wfull,
  output logic                     winc,
  output logic [DSIZE-1:0]         wdata,
  output logic                     gnt_valid,
  output logic [ARB_IDW(NREQ)-1:0] gnt_id
);

  localparam int IDW = ARB_IDW(NREQ);

  arb_state_e     state_q;
  logic [IDW-1:0] gnt_id_q;
  logic [IDW-1:0] last_q;

  logic           pick_any;
  logic [IDW-1:0] pick_idx;
  logic           hold_req;
  logic           xfer;
  logic           burst_done;
  logic           rel;
  logic           regrant;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req  (req),
    .last (last_q),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  // Write strobes come straight from the registered grant so the holder streams every cycle.
  assign hold_req = req[gnt_id_q];
  assign xfer     = (state_q == ARB_GRANT) && hold_req && !wfull && !wrst;
  assign winc     = xfer;
  assign ack      = xfer ? (NREQ'(1) << gnt_id_q) : '0;

  always_comb begin
    wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (xfer && (gnt_id_q == IDW'(i))) begin
        wdata = din[i*DSIZE +: DSIZE];
      end
    end
  end

`ifdef WR_ARB_BURST_EN
  localparam int BCW = $clog2(BURST_LEN + 1);

  logic [BCW-1:0] beat_q;

  assign burst_done = xfer && (beat_q == BCW'(BURST_LEN - 1));

  always_ff @(posedge wclk) begin
    if (wrst || regrant) begin
      beat_q <= '0;
    end else if (xfer && (beat_q != BCW'(BURST_LEN))) begin
      beat_q <= beat_q + 1'b1;
    end
  end
`else
  // BURST_LEN has no effect when every grant covers exactly one word.
  logic [31:0] unused_burst_len;
  assign unused_burst_len = 32'(BURST_LEN);
  assign burst_done       = xfer;
`endif

  assign rel     = (state_q == ARB_GRANT) && (!hold_req || burst_done);
  assign regrant = ((state_q == ARB_IDLE) || rel) && pick_any;

  // On release the picker runs in the same cycle, so handover costs no idle cycle.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      state_q  <= ARB_IDLE;
      gnt_id_q <= '0;
      last_q   <= IDW'(NREQ - 1);
    end else if ((state_q == ARB_IDLE) || rel) begin
      if (pick_any) begin
        state_q  <= ARB_GRANT;
        gnt_id_q <= pick_idx;
        last_q   <= pick_idx;
      end else begin
        state_q  <= ARB_IDLE;
        gnt_id_q <= '0;
      end
    end
  end

  assign gnt_valid = (state_q == ARB_GRANT);
  assign gnt_id    = gnt_id_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized scoreboard bench for fifo_wr_arbiter against a queue-based reference model.
module tb_fifo_wr_arbiter;

  localparam int NREQ  = 4;
  localparam int DSIZE = 128;
  localparam int BLEN  = 4;
`ifdef WR_ARB_BURST_EN
  localparam int BEATS = BLEN;
`else
  localparam int BEATS = 1;
`endif

  logic                  wclk = 1'b0;
  logic                  wrst = 1'b1;
  logic                  wfull = 1'b0;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*DSIZE-1:0] din = '0;
  logic [NREQ-1:0]       ack;
  logic                  winc;
  logic [DSIZE-1:0]      wdata;
  logic                  gnt_valid;
  logic [1:0]            gnt_id;

  fifo_wr_arbiter #(.NREQ(NREQ), .DSIZE(DSIZE), .BURST_LEN(BLEN)) dut (
    .wclk      (wclk),
    .wrst      (wrst),
    .req       (req),
    .din       (din),
    .ack       (ack),
    .wfull     (wfull),
    .winc      (winc),
    .wdata     (wdata),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  always #5 wclk = ~wclk;

  typedef struct { int cyc; int id; logic [DSIZE-1:0] dat; } wr_t;
  typedef struct { int cyc; bit vld; int id; } st_t;

  wr_t wr_q[$];
  st_t st_q[$];
  int  errors = 0;
  int  checks = 0;
  int  cyc = 0;
  bit  mon_en = 1'b0;
  logic [DSIZE-1:0] data_v [NREQ];

  // Reference model: holder = -1 when nobody owns the port.
  int holder = -1;
  int last   = NREQ - 1;
  int served = 0;

  always @(posedge wclk) cyc <= cyc + 1;

  function automatic logic [DSIZE-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string name, input logic [DSIZE-1:0] act, input logic [DSIZE-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic flag(input string name, input int exp_cyc);
    checks++;
    errors++;
    $display("FAIL %s cyc=%0d expected_at=%0d", name, cyc, exp_cyc);
  endtask

  // Predict this cycle's response from the inputs just applied, then advance the model.
  task automatic model_step();
    st_t s;
    wr_t w;
    bit  wr;
    s.cyc = cyc;
    s.vld = (holder >= 0);
    s.id  = (holder < 0) ? 0 : holder;
    st_q.push_back(s);
    wr = (holder >= 0) && req[holder[1:0]] && !wfull && !wrst;
    if (wr) begin
      w.cyc = cyc;
      w.id  = holder;
      w.dat = data_v[holder[1:0]];
      wr_q.push_back(w);
      served++;
      data_v[holder[1:0]] = rnd();
    end
    if (wrst) begin
      holder = -1;
      last   = NREQ - 1;
      served = 0;
    end else if (holder < 0 || !req[holder[1:0]] || (wr && served == BEATS)) begin
      holder = -1;
      served = 0;
      for (int i = 1; i <= NREQ; i++) begin
        int k;
        k = (last + i) % NREQ;
        if (holder < 0 && req[k[1:0]]) holder = k;
      end
      if (holder >= 0) last = holder;
    end
    mon_en = 1'b1;
  endtask

  task automatic run(input int n, input logic [NREQ-1:0] mask, input int full_pct,
                     input int drop_pct, input bit rst);
    for (int c = 0; c < n; c++) begin
      @(posedge wclk);
      #1;
      wrst  = rst;
      wfull = (int'($urandom_range(99)) < full_pct);
      for (int i = 0; i < NREQ; i++) begin
        req[i] = mask[i] && (int'($urandom_range(99)) >= drop_pct);
        din[i*DSIZE +: DSIZE] = data_v[i];
      end
      model_step();
    end
  endtask

  always @(negedge wclk) begin
    if (mon_en) begin
      st_t s;
      wr_t w;
      logic [NREQ-1:0] ea;
      if (st_q.size() == 0) begin
        flag("state_queue_empty", cyc);
      end else begin
        s = st_q.pop_front();
        chk("gnt_valid", DSIZE'(gnt_valid), DSIZE'(s.vld));
        chk("gnt_id", DSIZE'(gnt_id), DSIZE'(s.id));
      end
      while (wr_q.size() > 0 && wr_q[0].cyc < cyc) begin
        w = wr_q.pop_front();
        flag("missed_write", w.cyc);
      end
      if (winc) begin
        if (wr_q.size() > 0 && wr_q[0].cyc == cyc) begin
          w  = wr_q.pop_front();
          ea = '0;
          ea[w.id[1:0]] = 1'b1;
          chk("ack", DSIZE'(ack), DSIZE'(ea));
          chk("wdata", wdata, w.dat);
        end else begin
          flag("unexpected_winc", cyc);
        end
      end else begin
        chk("ack_idle", DSIZE'(ack), '0);
        if (wr_q.size() > 0 && wr_q[0].cyc == cyc) begin
          w = wr_q.pop_front();
          flag("missed_write", w.cyc);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < NREQ; i++) data_v[i] = rnd();
    repeat (2) @(posedge wclk);
    #1;
    chk("reset_winc", DSIZE'(winc), '0);
    chk("reset_ack", DSIZE'(ack), '0);
    chk("reset_wdata", wdata, '0);
    chk("reset_gnt_valid", DSIZE'(gnt_valid), '0);
    chk("reset_gnt_id", DSIZE'(gnt_id), '0);

    run(12, 4'b0101, 0, 0, 1'b0);
    run(10, 4'b1111, 0, 0, 1'b0);
    run(2,  4'b0000, 0, 0, 1'b0);
    run(2,  4'b0010, 0, 0, 1'b0);
    run(3,  4'b0010, 100, 0, 1'b0);
    run(6,  4'b0010, 0, 0, 1'b0);
    run(2,  4'b0000, 0, 0, 1'b0);
    run(2,  4'b1000, 0, 0, 1'b0);
    run(6,  4'b0011, 0, 0, 1'b0);
    run(2,  4'b0100, 0, 0, 1'b0);
    run(1,  4'b0100, 0, 0, 1'b1);
    run(4,  4'b0110, 0, 0, 1'b0);
    run(6,  4'b0100, 0, 0, 1'b0);
    run(300, 4'b1111, 20, 25, 1'b0);
    run(40, 4'b1111, 10, 10, 1'b0);
    run(1,  4'b1111, 0, 0, 1'b1);
    run(40, 4'b1011, 15, 30, 1'b0);
    run(4,  4'b0000, 0, 0, 1'b0);

    @(negedge wclk);
    #1;
    mon_en = 1'b0;
    while (wr_q.size() > 0) begin
      wr_t w;
      w = wr_q.pop_front();
      flag("write_never_seen", w.cyc);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
